// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, reset and
// chip-enable levels, NOP word, and the IF/ID payload struct.
package if_stage_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam logic       RST_ENABLE      = 1'b1;
  localparam logic       CHIP_ENABLE     = 1'b1;
  localparam logic       CHIP_DISABLE    = 1'b0;
  localparam inst_addr_t ZERO_WORD       = INST_ADDR_W'(0);
  localparam inst_t      NOP_INST        = INST_W'(0);
  localparam inst_addr_t PC_STEP         = INST_ADDR_W'(4);
  localparam inst_addr_t WORD_ALIGN_MASK = INST_ADDR_W'(32'hFFFF_FFFC);

  // IF/ID pipeline register payload
  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: ZERO_WORD, inst: NOP_INST};

  // Force an address onto a word boundary
  function automatic inst_addr_t word_align(input inst_addr_t addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: control from later stages, ROM port, IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline / ROM.
interface if_stage_if;
  import if_stage_pkg::*;

  logic       stall_pc_i;
  logic       stall_id_i;
  logic       branch_flag_i;
  inst_addr_t branch_target_i;
  logic       flush_i;
  inst_addr_t new_pc_i;
  logic       rom_ce_o;
  inst_addr_t rom_addr_o;
  inst_t      rom_data_i;
  inst_addr_t id_pc_o;
  inst_t      id_inst_o;

  modport master (
    input  stall_pc_i, stall_id_i, branch_flag_i, branch_target_i,
           flush_i, new_pc_i, rom_data_i,
    output rom_ce_o, rom_addr_o, id_pc_o, id_inst_o
  );

  modport slave (
    output stall_pc_i, stall_id_i, branch_flag_i, branch_target_i,
           flush_i, new_pc_i, rom_data_i,
    input  rom_ce_o, rom_addr_o, id_pc_o, id_inst_o
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble / hold / load selection.
// Build option BRANCH_DELAY_SLOT_EN: when defined, the word fetched alongside a
// taken branch enters IF/ID (MIPS delay slot); otherwise it is squashed.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       flush,
  input  logic       stall_pc,
  input  logic       stall_id,
  input  logic       branch_flag,
  input  inst_addr_t pc,
  input  inst_t      inst,
  output if_id_t     id
);

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic SQUASH_SHADOW = 1'b0;
`else
  localparam logic SQUASH_SHADOW = 1'b1;
`endif

  // Flush beats both stalls; a PC-only stall inserts a bubble downstream
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      id <= IF_ID_BUBBLE;
    end else if (ce == CHIP_DISABLE) begin
      id <= IF_ID_BUBBLE;
    end else if (flush) begin
      id <= IF_ID_BUBBLE;
    end else if (stall_pc && !stall_id) begin
      id <= IF_ID_BUBBLE;
    end else if (stall_id) begin
      id <= id;
    end else if (branch_flag && SQUASH_SHADOW) begin
      id <= IF_ID_BUBBLE;
    end else begin
      id <= '{pc: pc, inst: inst};
    end
  end

endmodule

// File: rtl/if_stage.sv
// MIPS32 instruction-fetch stage: program counter, ROM enable, next-PC
// priority mux (flush > stall > branch > sequential) and the IF/ID register.
// Build option BRANCH_DELAY_SLOT_EN selects delay-slot vs. squash behaviour
// (handled inside if_id_reg; PC behaviour is identical in both builds).
module if_stage
  import if_stage_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 32'h0000_0000
)
(
  input  logic              clk,
  input  logic              rst,
  if_stage_if.master        bus
);

  inst_addr_t pc;
  inst_addr_t pc_next_c;
  logic       ce;
  if_id_t     id;

  // Next PC; an illegal stall_id without stall_pc still freezes the PC
  always_comb begin
    pc_next_c = pc + PC_STEP;
    if (ce == CHIP_DISABLE) begin
      pc_next_c = word_align(RESET_PC);
    end else if (bus.flush_i) begin
      pc_next_c = word_align(bus.new_pc_i);
    end else if (bus.stall_pc_i || bus.stall_id_i) begin
      pc_next_c = pc;
    end else if (bus.branch_flag_i) begin
      pc_next_c = word_align(bus.branch_target_i);
    end
  end

  // PC and chip-enable registers; ce rises on the first edge out of reset
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pc <= word_align(RESET_PC);
      ce <= CHIP_DISABLE;
    end else begin
      pc <= pc_next_c;
      ce <= CHIP_ENABLE;
    end
  end

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .flush       (bus.flush_i),
    .stall_pc    (bus.stall_pc_i),
    .stall_id    (bus.stall_id_i),
    .branch_flag (bus.branch_flag_i),
    .pc          (pc),
    .inst        (bus.rom_data_i),
    .id          (id)
  );

  assign bus.rom_ce_o   = ce;
  assign bus.rom_addr_o = pc;
  assign bus.id_pc_o    = id.pc;
  assign bus.id_inst_o  = id.inst;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a cycle-level reference model pushes the
// expected post-edge state into a scoreboard queue, popped after each edge,
// plus directed checks against fixed addresses and words.
module tb_if_stage;

  typedef struct {
    logic [31:0] addr;
    logic        ce;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_t sb[$];

  logic [31:0] m_pc;
  logic        m_ce;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;

  if_stage_if ifc ();

  if_stage #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  always #5 clk = ~clk;

  // ROM image: every word is tagged so it never looks like a NOP
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[31:2], 2'b01};
  endfunction

  assign ifc.rom_data_i = rom_word(ifc.rom_addr_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge
  task automatic step(input logic r, input logic fl, input logic sp, input logic si,
                      input logic br, input logic [31:0] tgt, input logic [31:0] npc);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst                 = r;
    ifc.flush_i         = fl;
    ifc.stall_pc_i      = sp;
    ifc.stall_id_i      = si;
    ifc.branch_flag_i   = br;
    ifc.branch_target_i = tgt;
    ifc.new_pc_i        = npc;

    e.addr = m_pc; e.ce = m_ce; e.id_pc = m_id_pc; e.id_inst = m_id_inst;
    if (r) begin
      e = '{32'h0, 1'b0, 32'h0, 32'h0};
    end else begin
      e.ce = 1'b1;
      if (!m_ce)         e.addr = m_pc;
      else if (fl)       e.addr = npc & 32'hFFFF_FFFC;
      else if (sp || si) e.addr = m_pc;
      else if (br)       e.addr = tgt & 32'hFFFF_FFFC;
      else               e.addr = m_pc + 32'd4;

      if (!m_ce || fl || (sp && !si)) begin
        e.id_pc = 32'h0; e.id_inst = 32'h0;
      end else if (si) begin
        e.id_pc = m_id_pc; e.id_inst = m_id_inst;
`ifndef BRANCH_DELAY_SLOT_EN
      end else if (br) begin
        e.id_pc = 32'h0; e.id_inst = 32'h0;
`endif
      end else begin
        e.id_pc = m_pc; e.id_inst = rom_word(m_pc);
      end
    end
    m_pc = e.addr; m_ce = e.ce; m_id_pc = e.id_pc; m_id_inst = e.id_inst;
    sb.push_back(e);

    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("sb_rom_addr", ifc.rom_addr_o, g.addr);
    check("sb_rom_ce",   32'(ifc.rom_ce_o), 32'(g.ce));
    check("sb_id_pc",    ifc.id_pc_o, g.id_pc);
    check("sb_id_inst",  ifc.id_inst_o, g.id_inst);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] shadow_exp;
    rst = 1'b1;
    ifc.flush_i = 1'b0; ifc.stall_pc_i = 1'b0; ifc.stall_id_i = 1'b0;
    ifc.branch_flag_i = 1'b0; ifc.branch_target_i = 32'h0; ifc.new_pc_i = 32'h0;
    m_pc = 32'h0; m_ce = 1'b0; m_id_pc = 32'h0; m_id_inst = 32'h0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rst_ce",   32'(ifc.rom_ce_o), 32'h0);
    check("rst_addr", ifc.rom_addr_o, 32'h0);
    check("rst_inst", ifc.id_inst_o, 32'h0);

    // Sequential fetch from reset
    repeat (5) idle();
    check("seq_addr", ifc.rom_addr_o, 32'h10);
    check("seq_ce",   32'(ifc.rom_ce_o), 32'h1);
    check("seq_inst", ifc.id_inst_o, 32'h0000_000D);

    // Branch at PC=0x10 to 0x100
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0);
`ifdef BRANCH_DELAY_SLOT_EN
    shadow_exp = 32'h0000_0011;
`else
    shadow_exp = 32'h0;
`endif
    check("br_addr",   ifc.rom_addr_o, 32'h100);
    check("br_shadow", ifc.id_inst_o, shadow_exp);
    idle();
    check("br_target_inst", ifc.id_inst_o, 32'h0000_0101);

    // PC stall: frozen PC, bubbles
    repeat (3) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      check("stall_addr",   ifc.rom_addr_o, 32'h104);
      check("stall_bubble", ifc.id_inst_o, 32'h0);
    end
    idle();
    check("unstall_inst", ifc.id_inst_o, 32'h0000_0105);

    // Full stall: IF/ID held
    repeat (2) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      check("hold_pc",   ifc.id_pc_o, 32'h104);
      check("hold_inst", ifc.id_inst_o, 32'h0000_0105);
      check("hold_addr", ifc.rom_addr_o, 32'h108);
    end
    idle();

    // Flush overrides stall and branch; handler address alignment
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h400, 32'h181);
    check("flush_addr",  ifc.rom_addr_o, 32'h180);
    check("flush_inst",  ifc.id_inst_o, 32'h0);
    idle();
    check("handler_inst", ifc.id_inst_o, 32'h0000_0181);
    check("handler_pc",   ifc.id_pc_o, 32'h180);

    // PC wrap and target alignment
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    check("wrap_pre", ifc.rom_addr_o, 32'hFFFF_FFFC);
    idle();
    check("wrap_addr", ifc.rom_addr_o, 32'h0);
    check("wrap_inst", ifc.id_inst_o, 32'hFFFF_FFFD);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h203, 32'h0);
    check("align_addr", ifc.rom_addr_o, 32'h200);
    repeat (2) idle();

    // Mid-stream reset, even with events pending
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 32'h500);
    check("mrst_addr", ifc.rom_addr_o, 32'h0);
    check("mrst_ce",   32'(ifc.rom_ce_o), 32'h0);
    check("mrst_inst", ifc.id_inst_o, 32'h0);
    idle();
    check("mrst_ce_back", 32'(ifc.rom_ce_o), 32'h1);
    check("mrst_hold",    ifc.rom_addr_o, 32'h0);
    idle();
    check("mrst_resume",  ifc.rom_addr_o, 32'h4);

    // Randomised mix of legal events
    for (int i = 0; i < 80; i++) begin
      logic sp, si, br, fl, r;
      sp = ($urandom_range(3) == 0);
      si = sp & ($urandom_range(1) == 1);
      br = ($urandom_range(4) == 0);
      fl = ($urandom_range(15) == 0);
      r  = ($urandom_range(49) == 0);
      step(r, fl, sp, si, br, $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch front end of the MIPS32 five-stage pipeline: owns the program counter, drives the instruction ROM, and registers the fetched word and its PC into the IF/ID pipeline register consumed by the decoder. It honours stall requests from later stages, PC redirects from the decoder (branch/jump), and flushes from the exception logic. It is the producing end of the decoder's instruction input.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset; bits [1:0] must be 00.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall_pc_i  in  1  hold the PC this cycle.
- stall_id_i  in  1  hold the IF/ID register this cycle.
- branch_flag_i  in  1  decoder requests a redirect.
- branch_target_i  in  32  redirect address; bits [1:0] ignored and forced to 00.
- flush_i  in  1  exception flush.
- new_pc_i  in  32  exception handler address; bits [1:0] forced to 00.
- rom_ce_o  out  1  ROM chip enable, registered.
- rom_addr_o  out  32  equals the current PC.
- rom_data_i  in  32  instruction word; combinational from rom_addr_o in the same cycle.
- id_pc_o  out  32  PC of the instruction in IF/ID.
- id_inst_o  out  32  instruction in IF/ID; 32'h0 is a NOP bubble.

## Operation
- PC register `pc`, enable `ce`, IF/ID registers `id_pc`, `id_inst`.
- Reset: pc=RESET_PC, ce=0, id_pc=0, id_inst=0. rom_addr_o=RESET_PC.
- ce goes to 1 on the first edge with rst=0 and then stays 1.
- While ce=0, pc holds at RESET_PC and IF/ID loads a bubble.
- PC update priority (ce=1), highest first:
  - flush_i: pc<=new_pc_i.
  - stall_pc_i: pc holds. Any simultaneous branch_flag_i is ignored; the stalled decoder re-presents it.
  - branch_flag_i: pc<=branch_target_i.
  - Otherwise: pc<=pc+4, modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.
- IF/ID update priority:
  - flush_i: bubble (id_pc=0, id_inst=0). Flush overrides both stalls.
  - stall_pc_i=1 and stall_id_i=0: bubble.
  - stall_id_i=1: hold.
  - Otherwise: id_pc<=pc, id_inst<=rom_data_i. The branch-shadow rule is in Configuration.
- stall_id_i=1 with stall_pc_i=0 is illegal. In that case the PC holds anyway, so the PC holds whenever stall_id_i=1.
- pc[1:0] is always 00.

## Timing
- Fetch latency is 1 cycle: the word at PC p, presented on rom_addr_o in cycle n, appears on id_inst_o in cycle n+1.
- Throughput is 1 instruction/cycle when there are no stalls.
- Branch penalty:
  - With the delay slot: 0 cycles.
  - Without: 1 bubble.
- Flush: the handler's first instruction reaches id_inst_o 2 cycles after flush_i is sampled.
- rst asserted mid-operation takes effect on the next edge, regardless of flush, stall or branch.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: the instruction fetched in the same cycle that branch_flag_i=1 enters IF/ID normally. This is the MIPS delay slot.
- BRANCH_DELAY_SLOT_EN undefined: in that cycle IF/ID loads a bubble instead of rom_data_i, unless flush or a stall rule takes precedence.
- The PC update rules are identical in both builds.

## Structure
- Shared defines file entries:
  - InstAddrBus, InstBus.
  - RstEnable.
  - ZeroWord.
  - NOP instruction word 32'h0.
  - ChipEnable/ChipDisable.
- Sub-module `if_id_reg` holds the IF/ID register: bubble/hold/load logic and the delay-slot squash.
- `if_stage` holds the PC, ce, the priority mux, and instantiates `if_id_reg`.

## Test plan
- Reset release, no stalls, ROM word = address: rom_addr_o = 0,4,8,…; id_inst_o lags by one cycle; ce=1 from the first post-reset edge.
- branch_flag_i=1 with target 0x100 at PC=0x10: next rom_addr_o=0x100.
  - With the macro, id_inst_o shows the 0x10 word.
  - Without the macro, id_inst_o=0.
- stall_pc_i=1 for 3 cycles with stall_id_i=0: PC frozen and 3 bubbles. Then stall_pc_i=stall_id_i=1: id_pc_o/id_inst_o held unchanged.
- flush_i=1 with new_pc_i=0x180, concurrent with stall_pc_i=1 and branch_flag_i=1: pc=0x180 and IF/ID bubble on the next cycle.
- PC=0xFFFF_FFFC, no events: next PC=0x0000_0000. Branch target 0x203: PC=0x200.
- rst=1 for one cycle mid-stream: pc=RESET_PC, id_inst_o=0, ce=0. ce returns to 1 one cycle later.
